note_lane_sequencer: RTL and testbench

//  Game controller for the Guitar_Villains two-lane note display.
//  - Paces a song from an external note ROM into two 7-column scrolling rows.
//  - Judges player strikes against the hit column; tracks score and misses.
//  - Sequences the game IDLE -> COUNT -> PLAY -> DONE.
//  - Drives the row buses and status feeding the LED rows and 7-seg decoders.

---
 rtl/note_lane_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_note_lane_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_sequencer.sv
// note_lane_sequencer: game controller for a two-lane scrolling note display.
// Paces song entries from an external note ROM into two 7-column rows and
// judges player strikes in the hit column. It keeps a BCD score and a miss
// count, and sequences the game through IDLE -> COUNT -> PLAY -> DONE.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   start      start request (rising edge acts)
//   button     lane strike buttons, [0]=top, [1]=bottom (rising edge acts)
//   note_data  ROM data at note_addr, [0]=top, [1]=bottom
//   note_addr  song ROM address
//   top_row    top lane notes, bit6 = entry column, bit0 = hit column
//   bottom_row bottom lane notes, same layout
//   score_bcd  two-digit BCD hit count, saturating at 99
//   misses     binary miss count, saturating at MAX_MISS
//   state      0=IDLE 1=COUNT 2=PLAY 3=DONE
//   hit_pulse  one-cycle pulse for a cycle with at least one hit
//   miss_pulse one-cycle pulse for a step that dropped at least one note
module note_lane_sequencer #(
    parameter logic [23:0] STEP_DIV    = 24'd6_000_000,
    parameter int unsigned SONG_LEN    = 32,
    parameter int unsigned COUNT_STEPS = 3,
    parameter int unsigned MAX_MISS    = 9,
    localparam int unsigned AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    button,
    input  logic [1:0]    note_data,
    output logic [AW-1:0] note_addr,
    output logic [6:0]    top_row,
    output logic [6:0]    bottom_row,
    output logic [7:0]    score_bcd,
    output logic [3:0]    misses,
    output logic [1:0]    state,
    output logic          hit_pulse,
    output logic          miss_pulse
);

    localparam int unsigned PW = 24;
    localparam int unsigned CW = $clog2(COUNT_STEPS + 1);
    localparam int unsigned IW = $clog2(SONG_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [CW-1:0]  steps_q, steps_d;
    logic [IW-1:0]  inj_q, inj_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [6:0]     top_q, top_d;
    logic [6:0]     bot_q, bot_d;
    logic [7:0]     score_q, score_d;
    logic [3:0]     misses_q, misses_d;
    logic           hit_q, hit_d;
    logic           miss_q, miss_d;
    logic           start_q;
    logic [1:0]     button_q;

    logic           start_rise;
    logic [1:0]     btn_rise;
    logic           tick;
    logic [1:0]     lane_hit;
    logic [1:0]     lane_miss;
    logic [1:0]     inj;
    logic [6:0]     top_pre;
    logic [6:0]     bot_pre;
    logic [4:0]     miss_sum;
    logic [7:0]     score_tmp;

    assign start_rise = start & ~start_q;
    assign btn_rise   = button & ~button_q;
    assign tick       = (presc_q == STEP_DIV - 24'd1);

    // Saturating BCD increment: 99 holds, units 9 carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return 8'h99;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // State register and input edge-detect samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            steps_q  <= '0;
            inj_q    <= '0;
            addr_q   <= '0;
            top_q    <= '0;
            bot_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            start_q  <= 1'b0;
            button_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            steps_q  <= steps_d;
            inj_q    <= inj_d;
            addr_q   <= addr_d;
            top_q    <= top_d;
            bot_q    <= bot_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            start_q  <= start;
            button_q <= button;
        end
    end

    // Next-state, scrolling, hit judgement and scoring.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        steps_d   = steps_q;
        inj_d     = inj_q;
        addr_d    = addr_q;
        top_d     = top_q;
        bot_d     = bot_q;
        score_d   = score_q;
        misses_d  = misses_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        lane_hit  = 2'b00;
        lane_miss = 2'b00;
        inj       = 2'b00;
        top_pre   = top_q;
        bot_pre   = bot_q;
        miss_sum  = '0;
        score_tmp = score_q;

        unique case (state_q)
            S_IDLE: begin
                presc_d  = '0;
                steps_d  = '0;
                inj_d    = '0;
                addr_d   = '0;
                top_d    = '0;
                bot_d    = '0;
                score_d  = '0;
                misses_d = '0;
                if (start_rise) state_d = S_COUNT;
            end

            S_COUNT: begin
                presc_d = tick ? '0 : presc_q + 24'd1;
                if (tick) begin
                    if (steps_q == CW'(COUNT_STEPS - 1)) begin
                        steps_d = '0;
                        state_d = S_PLAY;
                    end else begin
                        steps_d = steps_q + CW'(1);
                    end
                end
            end

            S_PLAY: begin
                presc_d = tick ? '0 : presc_q + 24'd1;

                // Hits are judged before the scroll so a strike on a tick edge still scores.
                lane_hit = btn_rise & {bot_q[0], top_q[0]};
                top_pre  = {top_q[6:1], top_q[0] & ~lane_hit[0]};
                bot_pre  = {bot_q[6:1], bot_q[0] & ~lane_hit[1]};
                if (lane_hit[0]) score_tmp = bcd_inc(score_tmp);
                if (lane_hit[1]) score_tmp = bcd_inc(score_tmp);
                score_d = score_tmp;
                hit_d   = |lane_hit;
                top_d   = top_pre;
                bot_d   = bot_pre;

                if (tick) begin
                    if (inj_q < IW'(SONG_LEN)) begin
                        inj   = note_data;
                        inj_d = inj_q + IW'(1);
                        if (addr_q != AW'(SONG_LEN - 1)) addr_d = addr_q + AW'(1);
                    end
                    lane_miss = {bot_pre[0], top_pre[0]};
                    top_d     = {inj[0], top_pre[6:1]};
                    bot_d     = {inj[1], bot_pre[6:1]};
                    miss_sum  = 5'(misses_q) + 5'(lane_miss[0]) + 5'(lane_miss[1]);
                    misses_d  = (miss_sum >= 5'(MAX_MISS)) ? 4'(MAX_MISS) : miss_sum[3:0];
                    miss_d    = |lane_miss;
                    if ((misses_d == 4'(MAX_MISS)) ||
                        ((inj_d == IW'(SONG_LEN)) && (top_d == 7'd0) && (bot_d == 7'd0))) begin
                        state_d = S_DONE;
                        presc_d = '0;
                        top_d   = '0;
                        bot_d   = '0;
                    end
                end
            end

            S_DONE: begin
                presc_d = '0;
                top_d   = '0;
                bot_d   = '0;
                if (start_rise) begin
                    state_d  = S_COUNT;
                    steps_d  = '0;
                    inj_d    = '0;
                    addr_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign note_addr  = addr_q;
    assign top_row    = top_q;
    assign bottom_row = bot_q;
    assign score_bcd  = score_q;
    assign misses     = misses_q;
    assign state      = state_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_note_lane_sequencer.sv
// Bench for note_lane_sequencer: a small instance (4-entry song) driven by
// per-step vector tables, plus a long-song instance for score saturation.
module tb_note_lane_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, start_b;
    logic [1:0] button_a, button_b;
    logic [1:0] note_data_a, note_data_b;
    logic [1:0] note_addr_a;
    logic [5:0] note_addr_b;
    logic [6:0] top_a, bot_a, top_b, bot_b;
    logic [7:0] score_a, score_b;
    logic [3:0] misses_a, misses_b;
    logic [1:0] state_a, state_b;
    logic       hp_a, mp_a, hp_b, mp_b;

    logic [1:0] rom_a [4];
    assign note_data_a = rom_a[note_addr_a];
    assign note_data_b = 2'b11;

    note_lane_sequencer #(.STEP_DIV(24'd4), .SONG_LEN(4), .COUNT_STEPS(3), .MAX_MISS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .button(button_a), .note_data(note_data_a),
        .note_addr(note_addr_a), .top_row(top_a), .bottom_row(bot_a), .score_bcd(score_a),
        .misses(misses_a), .state(state_a), .hit_pulse(hp_a), .miss_pulse(mp_a));

    note_lane_sequencer #(.STEP_DIV(24'd2), .SONG_LEN(64), .COUNT_STEPS(1), .MAX_MISS(9)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .button(button_b), .note_data(note_data_b),
        .note_addr(note_addr_b), .top_row(top_b), .bottom_row(bot_b), .score_bcd(score_b),
        .misses(misses_b), .state(state_b), .hit_pulse(hp_b), .miss_pulse(mp_b));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // One scroll step: stimulus in the first cycle after a tick, expected values after the next tick.
    typedef struct {
        int         scen;
        logic       strt;
        logic [1:0] press;
        logic       hp;
        logic [6:0] top;
        logic [6:0] bot;
        logic [7:0] score;
        logic [3:0] miss;
        logic       mp;
        logic [1:0] st;
        logic [1:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int sc, input logic s, input logic [1:0] p, input logic h,
                                input logic [6:0] t, input logic [6:0] b, input logic [7:0] sco,
                                input logic [3:0] m, input logic mpv, input logic [1:0] stv,
                                input logic [1:0] ad);
        vec_t v;
        v.scen = sc; v.strt = s; v.press = p; v.hp = h; v.top = t; v.bot = b;
        v.score = sco; v.miss = m; v.mp = mpv; v.st = stv; v.addr = ad;
        return v;
    endfunction

    // Entered at the negedge just after a tick edge (or PLAY entry); leaves at the next such negedge.
    task automatic apply_step(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("s%0d.step%0d", v.scen, idx + 1);
        button_a = v.press;
        start_a  = v.strt;
        @(negedge clk);
        button_a = 2'b00;
        start_a  = 1'b0;
        chk({tag, " hit_pulse"}, 32'(hp_a), 32'(v.hp));
        repeat (3) @(negedge clk);
        chk({tag, " top_row"},    32'(top_a),       32'(v.top));
        chk({tag, " bottom_row"}, 32'(bot_a),       32'(v.bot));
        chk({tag, " score"},      32'(score_a),     32'(v.score));
        chk({tag, " misses"},     32'(misses_a),    32'(v.miss));
        chk({tag, " miss_pulse"}, 32'(mp_a),        32'(v.mp));
        chk({tag, " state"},      32'(state_a),     32'(v.st));
        chk({tag, " note_addr"},  32'(note_addr_a), 32'(v.addr));
    endtask

    task automatic run_scen(input int sc);
        int n = 0;
        foreach (vecs[i]) begin
            if (vecs[i].scen == sc) begin
                apply_step(vecs[i], n);
                n++;
            end
        end
    endtask

    // Start rise from IDLE/DONE; returns at the negedge after PLAY entry.
    task automatic start_game_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("count entry state",  32'(state_a),     32'd1);
        chk("count entry score",  32'(score_a),     32'd0);
        chk("count entry misses", 32'(misses_a),    32'd0);
        chk("count entry rows",   32'({top_a, bot_a}), 32'd0);
        chk("count entry addr",   32'(note_addr_a), 32'd0);
        repeat (11) @(negedge clk);
        chk("count hold state", 32'(state_a), 32'd1);
        @(negedge clk);
        chk("play entry state", 32'(state_a), 32'd2);
    endtask

    logic [6:0] ramp [7];

    initial begin
        // ---- vector tables ----
        ramp = '{7'h40, 7'h60, 7'h70, 7'h78, 7'h3C, 7'h1E, 7'h0F};
        // scen 1: ROM {01,00,10,00}, no buttons; a start pulse mid-PLAY is ignored
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h40, 7'h00, 8'h00, 0, 0, 2, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0, 7'h20, 7'h00, 8'h00, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h10, 7'h40, 8'h00, 0, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h08, 7'h20, 8'h00, 0, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h04, 7'h10, 8'h00, 0, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h02, 7'h08, 8'h00, 0, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h01, 7'h04, 8'h00, 0, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h00, 7'h02, 8'h00, 1, 1, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h00, 7'h01, 8'h00, 1, 0, 2, 3));
        vecs.push_back(mk(1, 0, 2'b00, 0, 7'h00, 7'h00, 8'h00, 2, 1, 3, 3));
        // scen 2 and 5 share the fill-up ramp with ROM all 11
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(2, 0, 2'b00, 0, ramp[k], ramp[k], 8'h00, 0, 0, 2, (k < 3) ? 2'(k + 1) : 2'd3));
        vecs.push_back(mk(2, 0, 2'b11, 1, 7'h07, 7'h07, 8'h02, 0, 0, 2, 3));
        vecs.push_back(mk(2, 0, 2'b11, 1, 7'h03, 7'h03, 8'h04, 0, 0, 2, 3));
        vecs.push_back(mk(2, 0, 2'b11, 1, 7'h01, 7'h01, 8'h06, 0, 0, 2, 3));
        vecs.push_back(mk(2, 0, 2'b11, 1, 7'h00, 7'h00, 8'h08, 0, 0, 3, 3));
        // scen 3: ROM {01,00,00,00}, top note walks to the hit column
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(3, 0, 2'b00, 0, 7'(7'h40 >> k), 7'h00, 8'h00, 0, 0, 2, (k < 3) ? 2'(k + 1) : 2'd3));
        // scen 5: ROM all 11, no buttons; two-lane miss clamps 4 -> 3 and ends the game
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(5, 0, 2'b00, 0, ramp[k], ramp[k], 8'h00, 0, 0, 2, (k < 3) ? 2'(k + 1) : 2'd3));
        vecs.push_back(mk(5, 0, 2'b00, 0, 7'h07, 7'h07, 8'h00, 2, 1, 2, 3));
        vecs.push_back(mk(5, 0, 2'b00, 0, 7'h00, 7'h00, 8'h00, 3, 1, 3, 3));

        // ---- reset ----
        reset = 1'b1; start_a = 0; start_b = 0; button_a = 0; button_b = 0;
        rom_a = '{2'b01, 2'b00, 2'b10, 2'b00};
        repeat (2) @(negedge clk);
        chk("reset state",  32'(state_a),  32'd0);
        chk("reset rows",   32'({top_a, bot_a}), 32'd0);
        chk("reset score",  32'(score_a),  32'd0);
        chk("reset misses", 32'(misses_a), 32'd0);
        chk("reset pulses", 32'({hp_a, mp_a}), 32'd0);
        reset = 1'b0;

        // ---- scen 1: two unhit notes drop ----
        start_game_a();
        run_scen(1);

        // ---- scen 2: every note struck with both buttons ----
        rom_a = '{2'b11, 2'b11, 2'b11, 2'b11};
        start_game_a();
        run_scen(2);
        button_a = 2'b11;
        @(negedge clk);
        button_a = 2'b00;
        chk("done press hit_pulse", 32'(hp_a),    32'd0);
        chk("done press score",     32'(score_a), 32'h08);

        // ---- scen 3: strike lands on the same edge as the tick ----
        rom_a = '{2'b01, 2'b00, 2'b00, 2'b00};
        start_game_a();
        run_scen(3);
        repeat (3) @(negedge clk);
        button_a = 2'b01;
        @(negedge clk);
        button_a = 2'b00;
        chk("tick hit score",      32'(score_a),  32'h01);
        chk("tick hit hit_pulse",  32'(hp_a),     32'd1);
        chk("tick hit miss_pulse", 32'(mp_a),     32'd0);
        chk("tick hit misses",     32'(misses_a), 32'd0);
        chk("tick hit top_row",    32'(top_a),    32'd0);
        chk("tick hit state",      32'(state_a),  32'd3);

        // ---- scen 5: miss clamp, then restart clears counters ----
        rom_a = '{2'b11, 2'b11, 2'b11, 2'b11};
        start_game_a();
        run_scen(5);
        start_game_a();

        // ---- reset in the middle of PLAY ----
        repeat (8) @(negedge clk);
        chk("pre-reset top_row", 32'(top_a), 32'h60);
        #2 reset = 1'b1;
        #1;
        chk("mid reset state",  32'(state_a),     32'd0);
        chk("mid reset rows",   32'({top_a, bot_a}), 32'd0);
        chk("mid reset score",  32'(score_a),     32'd0);
        chk("mid reset misses", 32'(misses_a),    32'd0);
        chk("mid reset addr",   32'(note_addr_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---- long song: score saturation and held buttons ----
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b count state", 32'(state_b), 32'd1);
        repeat (16) @(negedge clk);
        chk("b play state", 32'(state_b), 32'd2);
        chk("b full row",   32'(top_b),   32'h7F);
        for (int i = 0; i < 49; i++) begin
            button_b = 2'b11;
            @(negedge clk);
            button_b = 2'b00;
            if (i == 4) chk("b bcd carry", 32'(score_b), 32'h10);
            @(negedge clk);
        end
        chk("b score 98",  32'(score_b),  32'h98);
        chk("b no misses", 32'(misses_b), 32'd0);
        button_b = 2'b11;
        @(negedge clk);
        button_b = 2'b00;
        chk("b double hit sat", 32'(score_b), 32'h99);
        chk("b double hit hp",  32'(hp_b),    32'd1);
        @(negedge clk);
        button_b = 2'b11;
        @(negedge clk);
        chk("b extra hit sat", 32'(score_b), 32'h99);
        chk("b extra hit hp",  32'(hp_b),    32'd1);
        @(negedge clk);
        chk("b held hp tick", 32'(hp_b), 32'd0);
        @(negedge clk);
        chk("b held hp",      32'(hp_b),     32'd0);
        chk("b held note",    32'(top_b[0]), 32'd1);
        button_b = 2'b00;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
